ws2812_tx: RTL and testbench

//  Upstream driver for the WS2812 LED chain. Accepts 24-bit pixel words over a valid/ready handshake.

---
 rtl/ws2812_tx.sv | 152 +++++++++++++++
 tb/tb_ws2812_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_tx.sv
// rtl/ws2812_tx.sv - WS2812 NRZ serialiser with valid/ready pixel input and latch/reset interval.
// Optional status outputs (o_pix_cnt, o_underrun) are enabled by defining WS2812_TX_STATUS_EN.
module ws2812_tx #(
    parameter int CLK_PRD  = 50,
    parameter int T0H      = 350,
    parameter int T0L      = 800,
    parameter int T1H      = 700,
    parameter int T1L      = 600,
    parameter int RET      = 50000,
    parameter int NUM_LEDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] i_pixel,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_serial,
    output logic        o_busy,
`ifdef WS2812_TX_STATUS_EN
    output logic [$clog2(NUM_LEDS+1)-1:0] o_pix_cnt,
    output logic        o_underrun,
`endif
    output logic        o_frame_done
);

    localparam int T0H_CYC = T0H / CLK_PRD;
    localparam int T0L_CYC = T0L / CLK_PRD;
    localparam int T1H_CYC = T1H / CLK_PRD;
    localparam int T1L_CYC = T1L / CLK_PRD;
    localparam int RST_CYC = RET / CLK_PRD;
    localparam int TW      = $clog2(RST_CYC + 1);
    localparam int PW      = $clog2(NUM_LEDS + 1);

    if (T0H_CYC < 1 || T0L_CYC < 1 || T1H_CYC < 1 || T1L_CYC < 1 || RST_CYC < 1 || NUM_LEDS < 1)
    begin : g_bad_timing
        $error("ws2812_tx: every timing constant must be at least one clock cycle");
    end

    typedef enum logic [1:0] {S_RESET, S_IDLE, S_HIGH, S_LOW} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [23:0]     shift_q, shift_d;
    logic [4:0]      bit_q, bit_d;
    logic [PW-1:0]   pix_q, pix_d;
    logic            serial_q, busy_q;
    logic [TW-1:0]   hi_last, lo_last;
    logic            more_pix;

    // Pulse lengths follow the bit currently at the top of the shift register.
    assign hi_last  = shift_q[23] ? TW'(T1H_CYC - 1) : TW'(T0H_CYC - 1);
    assign lo_last  = shift_q[23] ? TW'(T1L_CYC - 1) : TW'(T0L_CYC - 1);
    assign more_pix = (pix_q < PW'(NUM_LEDS - 1));

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + TW'(1);
        shift_d      = shift_q;
        bit_d        = bit_q;
        pix_d        = pix_q;
        o_ready      = 1'b0;
        o_frame_done = 1'b0;
        unique case (state_q)
            S_RESET: begin
                pix_d = '0;
                if (timer_q == TW'(RST_CYC - 1)) begin
                    o_frame_done = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    shift_d = i_pixel;
                    bit_d   = '0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (timer_q == hi_last) state_d = S_LOW;
            end
            S_LOW: begin
                if (timer_q == lo_last) begin
                    if (bit_q != 5'd23) begin
                        shift_d = {shift_q[22:0], 1'b0};
                        bit_d   = bit_q + 5'd1;
                        state_d = S_HIGH;
                    end else if (more_pix) begin
                        // Back-to-back window: the next pixel must be offered on exactly this cycle.
                        o_ready = 1'b1;
                        if (i_valid) begin
                            shift_d = i_pixel;
                            bit_d   = '0;
                            pix_d   = pix_q + PW'(1);
                            state_d = S_HIGH;
                        end else begin
                            pix_d   = '0;
                            state_d = S_RESET;
                        end
                    end else begin
                        pix_d   = '0;
                        state_d = S_RESET;
                    end
                end
            end
            default: state_d = S_RESET;
        endcase
        if (state_d != state_q || state_q == S_IDLE) timer_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RESET;
            timer_q  <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            pix_q    <= '0;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            pix_q    <= pix_d;
            serial_q <= (state_d == S_HIGH);
            busy_q   <= (state_d != S_IDLE);
        end
    end

    assign o_serial = serial_q;
    assign o_busy   = busy_q;

`ifdef WS2812_TX_STATUS_EN
    logic underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q;
        if (state_q == S_LOW && timer_q == lo_last && bit_q == 5'd23 && more_pix && !i_valid)
            underrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) underrun_q <= 1'b0;
        else        underrun_q <= underrun_d;
    end

    assign o_pix_cnt  = pix_q;
    assign o_underrun = underrun_q;
`endif

endmodule

// File: tb/tb_ws2812_tx.sv
// tb/tb_ws2812_tx.sv - Self-checking bench for ws2812_tx with a waveform model and pulse decoder.
module tb_ws2812_tx;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] i_pixel = '0;
    logic        i_valid = 1'b0;
    logic        o_ready, o_serial, o_busy, o_frame_done;
`ifdef WS2812_TX_STATUS_EN
    logic [1:0]  o_pix_cnt;
    logic        o_underrun;
`endif

    ws2812_tx #(.NUM_LEDS(N)) dut (
        .clk(clk), .rst_n(rst_n), .i_pixel(i_pixel), .i_valid(i_valid),
        .o_ready(o_ready), .o_serial(o_serial), .o_busy(o_busy),
`ifdef WS2812_TX_STATUS_EN
        .o_pix_cnt(o_pix_cnt), .o_underrun(o_underrun),
`endif
        .o_frame_done(o_frame_done)
    );

    always #25 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int smp = 0;
    // Expected {serial, ready, busy, frame_done} per sampled cycle
    logic [3:0] exp_q[$];
    logic [23:0] dec_q[$];
    int pw_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [3:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("wave[%0d] {ser,rdy,busy,fd}", smp),
                {28'd0, o_serial, o_ready, o_busy, o_frame_done}, {28'd0, e});
            smp++;
        end
    end

    // Downstream decoder: long high pulse = '1', short = '0', long low run = latch.
    int hi_len = 0, lo_len = 0, nb = 0;
    logic [23:0] word = '0;
    always @(negedge clk) begin
        if (o_serial) begin
            hi_len++;
            lo_len = 0;
        end else begin
            if (hi_len > 0) begin
                pw_q.push_back(hi_len);
                word = {word[22:0], (hi_len >= 11)};
                nb++;
                if (nb == 24) begin
                    dec_q.push_back(word);
                    nb = 0;
                end
            end
            hi_len = 0;
            lo_len++;
            if (lo_len > 200) nb = 0;
        end
    end

    function automatic logic [31:0] dec_at(input int i);
        return (dec_q.size() > i) ? {8'd0, dec_q[i]} : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] pw_at(input int i);
        return (pw_q.size() > i) ? pw_q[i] : 32'hxxxxxxxx;
    endfunction

    task automatic push_reset(input bit first);
        exp_q.push_back(first ? 4'b0000 : 4'b0010);
        repeat (998) exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0011);
    endtask

    task automatic push_frame(input logic [23:0] px[3], input int n);
        exp_q.push_back(4'b0100);
        for (int i = 0; i < n; i++) begin
            for (int b = 23; b >= 0; b--) begin
                int h, l;
                h = px[i][b] ? 14 : 7;
                l = px[i][b] ? 12 : 16;
                repeat (h) exp_q.push_back(4'b1010);
                repeat (l - 1) exp_q.push_back(4'b0010);
                exp_q.push_back((b == 0 && i < N - 1) ? 4'b0110 : 4'b0010);
            end
        end
        push_reset(0);
    endtask

    task automatic wait_empty(input string name);
        for (int k = 0; k < 4000 && exp_q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout %s remaining %0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called at posedge+1 while idle; returns at posedge+1.
    task automatic send(input logic [23:0] px[3], input int n, input bit noise, input int abort_at);
        int idx, cyc;
        bit xfer;
        chk("send_starts_idle", {31'd0, o_ready}, 32'd1);
        push_frame(px, n);
        i_valid = 1'b1;
        i_pixel = px[0];
        idx = 0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 8000) begin
            @(negedge clk);
            xfer = i_valid & o_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (abort_at != 0 && cyc == abort_at) return;
            if (xfer) begin
                idx++;
                if (idx < n) i_pixel = px[idx];
                else i_valid = 1'b0;
            end
            if (noise && idx >= n) begin
                i_pixel = 24'($urandom);
                i_valid = o_ready ? 1'b0 : 1'($urandom_range(0, 1));
            end
        end
        i_valid = 1'b0;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout send remaining %0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    int d0, p0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_serial", {31'd0, o_serial}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_frame_done", {31'd0, o_frame_done}, 32'd0);
`ifdef WS2812_TX_STATUS_EN
        chk("rst_underrun", {31'd0, o_underrun}, 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_reset(1);
        wait_empty("power_up");

        // Single pixel, then underrun (frame is 3 pixels long)
        d0 = dec_q.size();
        p0 = pw_q.size();
        send('{24'h800001, 24'h0, 24'h0}, 1, 1'b0, 0);
        chk("dec_800001", dec_at(d0), 32'h800001);
        chk("pw_bit23", pw_at(p0), 32'd14);
        chk("pw_bit22", pw_at(p0 + 1), 32'd7);
        chk("pw_bit0", pw_at(p0 + 23), 32'd14);
`ifdef WS2812_TX_STATUS_EN
        chk("underrun_set", {31'd0, o_underrun}, 32'd1);
        chk("pix_cnt_idle", {30'd0, o_pix_cnt}, 32'd0);
`endif

        // Full back-to-back frame
        d0 = dec_q.size();
        send('{24'hA5A5A5, 24'h5A5A5A, 24'hFFFFFF}, 3, 1'b0, 0);
        chk("dec_A5A5A5", dec_at(d0), 32'hA5A5A5);
        chk("dec_5A5A5A", dec_at(d0 + 1), 32'h5A5A5A);
        chk("dec_FFFFFF", dec_at(d0 + 2), 32'hFFFFFF);

        // Input noise while shifting must not disturb the waveform
        d0 = dec_q.size();
        send('{24'h800001, 24'h0, 24'h0}, 1, 1'b1, 0);
        chk("dec_noise_800001", dec_at(d0), 32'h800001);

        // Asynchronous reset in the high phase of bit 10
        send('{24'h800001, 24'h0, 24'h0}, 1, 1'b0, 305);
        chk("abort_serial_before", {31'd0, o_serial}, 32'd1);
        exp_q.delete();
        rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("abort_serial_after", {31'd0, o_serial}, 32'd0);
        chk("abort_busy_after", {31'd0, o_busy}, 32'd0);
        chk("abort_ready_after", {31'd0, o_ready}, 32'd0);
`ifdef WS2812_TX_STATUS_EN
        chk("abort_underrun_cleared", {31'd0, o_underrun}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_reset(1);
        wait_empty("abort_reset");
        repeat (3) exp_q.push_back(4'b0100);
        wait_empty("abort_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
